muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_if.sv | 9 +
 rtl/muldiv_timer.sv | 24 ++
 rtl/muldiv_sequencer.sv | 130 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared states, request encodings and watchdog default for the mul/div sequencer
package muldiv_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        M_START = 3'd1,
        M_WAIT  = 3'd2,
        D_START = 3'd3,
        D_WAIT  = 3'd4,
        WRITE   = 3'd5,
        EXC     = 3'd6
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request handshake between control unit and mul/div sequencer
interface muldiv_if;
    logic       req_valid;
    logic [1:0] req_op;
    logic       req_ready;

    modport master (output req_valid, output req_op, input req_ready);
    modport slave  (input req_valid, input req_op, output req_ready);
endinterface

// File: rtl/muldiv_timer.sv
// rtl/muldiv_timer.sv - wait-cycle watchdog; expired flags the limit-th enabled cycle since clear
module muldiv_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (enable) begin
            cnt <= cnt + 8'd1;
        end
    end

    // cnt holds the number of completed wait cycles, so the current cycle is cnt+1
    assign expired = enable && (cnt == (limit - 8'd1));
endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - mul/div operation sequencer; optional wait watchdog under MULDIV_TIMEOUT_EN
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  req,
    output logic     mult_control,
    input  logic     mult_stop,
    output logic     div_control,
    input  logic     div_stop,
    input  logic     div_zero,
    output logic     sel_mux_hi,
    output logic     sel_mux_lo,
    output logic     HiLo_load,
    output logic     done,
    output logic     exc_div_zero,
    output logic     timeout
);
    state_e state, state_next;
    logic   sel_q;
    logic   accept;
    logic   ready_c;
    logic   expired;

`ifdef MULDIV_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    muldiv_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state == M_START) || (state == D_START)),
        .enable  ((state == M_WAIT) || (state == D_WAIT)),
        .limit   (LIMIT),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sel_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                sel_q <= (req.req_op == OP_MULT);
            end
        end
    end

    always_comb begin
        state_next   = state;
        ready_c      = 1'b0;
        accept       = 1'b0;
        mult_control = 1'b0;
        div_control  = 1'b0;
        HiLo_load    = 1'b0;
        done         = 1'b0;
        exc_div_zero = 1'b0;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (req.req_valid && (req.req_op == OP_MULT)) begin
                    accept     = 1'b1;
                    state_next = M_START;
                end else if (req.req_valid && (req.req_op == OP_DIV)) begin
                    accept     = 1'b1;
                    state_next = D_START;
                end
            end
            M_START: begin
                mult_control = 1'b1;
                state_next   = M_WAIT;
            end
            D_START: begin
                div_control = 1'b1;
                state_next  = div_zero ? EXC : D_WAIT;
            end
            M_WAIT: begin
                if (mult_stop) begin
                    state_next = WRITE;
                end else if (expired) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            D_WAIT: begin
                // divide-by-zero outranks a simultaneous stop
                if (div_zero) begin
                    state_next = EXC;
                end else if (div_stop) begin
                    state_next = WRITE;
                end else if (expired) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                HiLo_load  = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            EXC: begin
                exc_div_zero = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // state may still hold a busy value until the reset edge, so mask outputs directly
        if (!reset) begin
            ready_c      = 1'b0;
            accept       = 1'b0;
            mult_control = 1'b0;
            div_control  = 1'b0;
            HiLo_load    = 1'b0;
            done         = 1'b0;
            exc_div_zero = 1'b0;
            timeout      = 1'b0;
        end
    end

    assign req.req_ready = ready_c;
    assign sel_mux_hi    = sel_q;
    assign sel_mux_lo    = sel_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mult_stop = 1'b0;
    logic div_stop = 1'b0;
    logic div_zero = 1'b0;
    logic mult_control, div_control, sel_mux_hi, sel_mux_lo;
    logic HiLo_load, done, exc_div_zero, timeout;

    int checks = 0;
    int errors = 0;

    muldiv_if bus ();

    muldiv_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (bus),
        .mult_control (mult_control),
        .mult_stop    (mult_stop),
        .div_control  (div_control),
        .div_stop     (div_stop),
        .div_zero     (div_zero),
        .sel_mux_hi   (sel_mux_hi),
        .sel_mux_lo   (sel_mux_lo),
        .HiLo_load    (HiLo_load),
        .done         (done),
        .exc_div_zero (exc_div_zero),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        int         d;
        bit         zero;
        bit         both;
        int         exp_end;
        bit         exp_write;
        bit         exp_sel;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Transaction-level reference: stop/zero arrives d cycles after the start pulse,
    // the commit or abort is visible in the following cycle, a zero flag aborts a DIV.
    function automatic vec_t model(input logic [1:0] op, input int d, input bit zero, input bit both);
        vec_t v;
        v.op        = op;
        v.d         = d;
        v.zero      = zero;
        v.both      = both;
        v.exp_end   = 2 + d;
        v.exp_write = !(op == OP_DIV && zero);
        v.exp_sel   = (op == OP_MULT);
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int  n_mc = 0;
        int  n_dc = 0;
        int  end_k = -1;
        bit  saw_load = 0, saw_done = 0, saw_exc = 0, saw_to = 0, ready_busy = 0;
        bit  got_ready = 0;
        logic s_hi = 1'bx, s_lo = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.req_ready === 1'b1) begin
                got_ready = 1;
                break;
            end
        end
        check({tag, "_ready_wait"}, 32'(got_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            mult_stop = (v.op == OP_MULT) && (k == 1 + v.d);
            div_zero  = (v.op == OP_DIV) && v.zero && (k == 1 + v.d);
            div_stop  = (v.op == OP_DIV) && (k == 1 + v.d) && (!v.zero || v.both);
            #1;
            n_mc += int'(mult_control);
            n_dc += int'(div_control);
            if (bus.req_ready) ready_busy = 1;
            if (timeout) saw_to = 1;
            if (HiLo_load) saw_load = 1;
            if (done) saw_done = 1;
            if (exc_div_zero) saw_exc = 1;
            if (done || exc_div_zero) begin
                end_k = k;
                s_hi  = sel_mux_hi;
                s_lo  = sel_mux_lo;
                break;
            end
            @(negedge clk);
        end
        mult_stop = 1'b0;
        div_stop  = 1'b0;
        div_zero  = 1'b0;
        check({tag, "_end_cycle"}, 32'(end_k), 32'(v.exp_end));
        check({tag, "_hilo_load"}, 32'(saw_load), 32'(v.exp_write));
        check({tag, "_done"}, 32'(saw_done), 32'(v.exp_write));
        check({tag, "_exc"}, 32'(saw_exc), 32'(!v.exp_write));
        check({tag, "_mult_pulses"}, 32'(n_mc), (v.op == OP_MULT) ? 32'd1 : 32'd0);
        check({tag, "_div_pulses"}, 32'(n_dc), (v.op == OP_DIV) ? 32'd1 : 32'd0);
        check({tag, "_ready_busy"}, 32'(ready_busy), 32'd0);
        check({tag, "_timeout"}, 32'(saw_to), 32'd0);
        check({tag, "_sel_hi"}, 32'(s_hi), 32'(v.exp_sel));
        check({tag, "_sel_lo"}, 32'(s_lo), 32'(v.exp_sel));
        @(negedge clk);
        #1;
        check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_load_after"}, 32'(HiLo_load), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        logic [7:0] mc_v, rdy_v, dn_v;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_MULT;

        vecs[0] = '{OP_MULT, 5, 1'b0, 1'b0, 7, 1'b1, 1'b1};
        vecs[1] = '{OP_DIV,  3, 1'b0, 1'b0, 5, 1'b1, 1'b0};
        vecs[2] = '{OP_DIV,  2, 1'b1, 1'b1, 4, 1'b0, 1'b0};
        vecs[3] = '{OP_DIV,  0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        vecs[4] = '{OP_MULT, 1, 1'b0, 1'b0, 3, 1'b1, 1'b1};
        vecs[5] = '{OP_DIV,  1, 1'b1, 1'b0, 3, 1'b0, 1'b0};

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_load", 32'(HiLo_load), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mult_ctl", 32'(mult_control), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_sel", 32'({sel_mux_hi, sel_mux_lo}), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            logic [1:0] op;
            int d;
            bit z;
            op = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
            d  = $urandom_range(1, 6);
            z  = (op == OP_DIV) && ($urandom_range(0, 3) == 0);
            run_op(model(op, d, z, 1'($urandom_range(0, 1))), $sformatf("rnd%0d", i));
        end

        // reserved op is ignored, then a request held through a MULT is taken back-to-back
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("rsv_ready%0d", i), 32'(bus.req_ready), 32'd1);
            check($sformatf("rsv_ctl%0d", i), 32'({mult_control, div_control}), 32'd0);
        end
        bus.req_op = OP_MULT;
        mc_v = '0; rdy_v = '0; dn_v = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            mult_stop = (k == 3) || (k == 7);
            if (k == 6) bus.req_valid = 1'b0;
            #1;
            mc_v[k-1]  = mult_control;
            rdy_v[k-1] = bus.req_ready;
            dn_v[k-1]  = done;
        end
        mult_stop = 1'b0;
        check("b2b_mult_pulses", 32'(mc_v), 32'h21);
        check("b2b_ready", 32'(rdy_v), 32'h10);
        check("b2b_done", 32'(dn_v), 32'h88);

        // reset during M_WAIT followed by a stale stop
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MULT;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_load", 32'(HiLo_load), 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        mult_stop = 1'b1;
        #1;
        check("mid_rst_ready_release", 32'(bus.req_ready), 32'd1);
        check("mid_rst_done", 32'({done, HiLo_load}), 32'd0);
        @(negedge clk);
        mult_stop = 1'b0;
        #1;
        check("stale_stop_done", 32'({done, HiLo_load}), 32'd0);
        check("stale_stop_sel", 32'({sel_mux_hi, sel_mux_lo}), 32'd0);
        check("stale_stop_ready", 32'(bus.req_ready), 32'd1);

`ifdef MULDIV_TIMEOUT_EN
        begin
            int to_k = -1;
            bit loaded = 0;
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = OP_DIV;
            @(negedge clk);
            bus.req_valid = 1'b0;
            for (int k = 1; k <= 30; k++) begin
                #1;
                if (HiLo_load) loaded = 1;
                if (timeout) begin
                    to_k = k;
                    break;
                end
                @(negedge clk);
            end
            check("to_cycle", 32'(to_k), 32'(1 + TO));
            check("to_no_load", 32'(loaded), 32'd0);
            @(negedge clk);
            #1;
            check("to_idle_ready", 32'(bus.req_ready), 32'd1);
            check("to_pulse_once", 32'(timeout), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
